imem_loader: RTL and testbench

Instruction-memory loader for the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes each word into consecutive instruction-memory locations and holds the core in reset until a complete program image has been written. It is the write-side counterpart of the core's instruction fetch path.

---
 rtl/imem_loader.sv | 108 ++++++++++
 tb/tb_imem_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Byte-stream instruction-memory loader. Assembles big-endian
//            32-bit words, writes consecutive addresses and holds the core
//            in reset until the whole program image has been written.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i8,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_waddr_o,
    output logic [31:0]       imem_wdata_o32,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RECV  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [ADDR_W:0] c_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]      r_state;
    logic [ADDR_W:0] r_len;
    logic [ADDR_W:0] r_wcnt;
    logic [1:0]      r_bcnt;
    logic [31:0]     r_word;
    logic            r_cpu_rst;

    logic [ADDR_W:0] w_len_clamped;
    logic [ADDR_W:0] w_wcnt_inc;

    // Lengths beyond the memory depth are clamped so addresses never wrap.
    assign w_len_clamped = (len_i > c_MAX_LEN) ? c_MAX_LEN : len_i;
    assign w_wcnt_inc    = r_wcnt + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= c_IDLE;
            r_len     <= '0;
            r_wcnt    <= '0;
            r_bcnt    <= '0;
            r_word    <= '0;
            r_cpu_rst <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start_i) begin
                        r_len  <= w_len_clamped;
                        r_wcnt <= '0;
                        r_bcnt <= '0;
                        if (len_i == '0) begin
                            r_state   <= c_DONE;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_state   <= c_RECV;
                            r_cpu_rst <= 1'b1;
                        end
                    end
                end
                c_RECV: begin
                    if (byte_valid_i) begin
                        r_word <= {r_word[23:0], byte_i8};
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_state <= c_WRITE;
                        end
                    end
                end
                c_WRITE: begin
                    r_wcnt <= w_wcnt_inc;
                    r_bcnt <= '0;
                    if (w_wcnt_inc == r_len) begin
                        r_state   <= c_DONE;
                        r_cpu_rst <= 1'b0;
                    end else begin
                        r_state <= c_RECV;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // All outputs decode from registered state only; no input-to-output path.
    assign byte_ready_o   = (r_state == c_RECV);
    assign imem_we_o      = (r_state == c_WRITE);
    assign busy_o         = (r_state == c_RECV) || (r_state == c_WRITE);
    assign done_o         = (r_state == c_DONE);
    assign cpu_rst_o      = r_cpu_rst;
    assign imem_waddr_o   = r_wcnt[ADDR_W-1:0];
    assign imem_wdata_o32 = r_word;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Self-checking bench for imem_loader: vector table, hand-written
//            reset corner cases and randomized sessions against a word model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk;
    logic              rst_i;
    logic              start_i;
    logic [ADDR_W:0]   len_i;
    logic              byte_valid_i;
    logic [7:0]        byte_i8;
    logic              byte_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_waddr_o;
    logic [31:0]       imem_wdata_o32;
    logic              cpu_rst_o;
    logic              busy_o;
    logic              done_o;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .len_i          (len_i),
        .byte_valid_i   (byte_valid_i),
        .byte_i8        (byte_i8),
        .byte_ready_o   (byte_ready_o),
        .imem_we_o      (imem_we_o),
        .imem_waddr_o   (imem_waddr_o),
        .imem_wdata_o32 (imem_wdata_o32),
        .cpu_rst_o      (cpu_rst_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        wr_q[$];
    int         done_cnt;
    int         ready_cnt;
    int         wr_ready_clash;
    logic [7:0] src_q[$];
    logic [7:0] img[$];
    logic [7:0] fixed_b[8];

    always @(negedge clk) begin
        if (imem_we_o) wr_q.push_back('{imem_waddr_o, imem_wdata_o32});
        if (done_o) done_cnt++;
        if (byte_ready_o) ready_cnt++;
        if (imem_we_o && byte_ready_o) wr_ready_clash++;
    end

    function automatic int eff_len(input int l);
        return (l > DEPTH) ? DEPTH : l;
    endfunction

    task automatic load_image(input int l, input bit fixed);
        img.delete();
        src_q.delete();
        for (int i = 0; i < 4 * eff_len(l); i++) begin
            logic [7:0] b;
            b = (fixed && i < 8) ? fixed_b[i] : 8'($urandom_range(0, 255));
            img.push_back(b);
            src_q.push_back(b);
        end
    endtask

    task automatic run_session(input int l, input int mode, input int mid_start, output int done_t);
        int t;
        bit acc;
        bit seen;
        bit rst_dropped_busy;
        wr_q.delete();
        done_cnt = 0;
        ready_cnt = 0;
        wr_ready_clash = 0;
        done_t = -1;
        seen = 0;
        rst_dropped_busy = 0;
        len_i = (ADDR_W+1)'(l);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        t = 1;
        while (!seen && t < 6000) begin
            if (done_o) begin
                seen = 1;
                done_t = t;
                check("cpu_rst_in_done", cpu_rst_o, 0);
                check("busy_in_done", busy_o, 0);
            end
            if (busy_o && !cpu_rst_o) rst_dropped_busy = 1;
            start_i = (t == mid_start);
            if (start_i) len_i = (ADDR_W+1)'($urandom_range(1, 127));
            case (mode)
                0:       byte_valid_i = 1'b1;
                1:       byte_valid_i = (t % 3 == 1);
                default: byte_valid_i = 1'($urandom_range(0, 1));
            endcase
            if (src_q.size() == 0) byte_valid_i = 1'b0;
            byte_i8 = (src_q.size() > 0) ? src_q[0] : 8'($urandom_range(0, 255));
            acc = byte_valid_i && byte_ready_o;
            @(posedge clk); #1;
            if (acc) void'(src_q.pop_front());
            t++;
        end
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        check("session_done_seen", seen, 1);
        check("done_drops", done_o, 0);
        check("cpu_rst_held_while_busy", rst_dropped_busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic verify(input string tag, input int l, input int exp_done_t, input int done_t);
        int n;
        n = eff_len(l);
        check({tag, " write_count"}, wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            check($sformatf("%s write_addr[%0d]", tag, i), wr_q[i].addr, i);
            check($sformatf("%s write_data[%0d]", tag, i), wr_q[i].data,
                  {img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]});
        end
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " ready_during_write"}, wr_ready_clash, 0);
        check({tag, " bytes_consumed"}, src_q.size(), 0);
        if (l == 0) check({tag, " ready_never_high"}, ready_cnt, 0);
        if (exp_done_t >= 0) check({tag, " done_cycle"}, done_t, exp_done_t);
    endtask

    typedef struct {
        int len;
        int mode;
        int mid_start;
        bit fixed;
        int exp_done_t;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int dt;
        bit acc;
        fixed_b = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        // RECV is entered in cycle 1; each word costs 5 cycles, DONE follows.
        vecs[0] = '{2,  0, 0,  1, 11};
        vecs[1] = '{2,  1, 0,  1, -1};
        vecs[2] = '{0,  0, 0,  0, 1};
        vecs[3] = '{1,  0, 0,  0, 6};
        vecs[4] = '{65, 0, 20, 0, 321};

        rst_i = 1'b1;
        start_i = 1'b0;
        len_i = '0;
        byte_valid_i = 1'b0;
        byte_i8 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check("reset cpu_rst", cpu_rst_o, 1);
        check("reset byte_ready", byte_ready_o, 0);
        check("reset imem_we", imem_we_o, 0);
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset waddr", imem_waddr_o, 0);
        check("reset wdata", imem_wdata_o32, 0);
        repeat (20) @(posedge clk);
        #1;
        check("idle cpu_rst held", cpu_rst_o, 1);
        check("idle busy", busy_o, 0);

        for (int v = 0; v < 5; v++) begin
            load_image(vecs[v].len, vecs[v].fixed);
            run_session(vecs[v].len, vecs[v].mode, vecs[v].mid_start, dt);
            verify($sformatf("vec%0d", v), vecs[v].len, vecs[v].exp_done_t, dt);
        end

        // Reset after two bytes of the second word: the partial word is lost.
        wr_q.delete();
        src_q.delete();
        for (int i = 0; i < 6; i++) src_q.push_back(fixed_b[i]);
        len_i = 7'd2;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            byte_valid_i = (src_q.size() > 0);
            byte_i8 = (src_q.size() > 0) ? src_q[0] : 8'h00;
            acc = byte_valid_i && byte_ready_o;
            @(posedge clk); #1;
            if (acc) void'(src_q.pop_front());
        end
        byte_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check("midrst cpu_rst", cpu_rst_o, 1);
        check("midrst busy", busy_o, 0);
        check("midrst ready", byte_ready_o, 0);
        repeat (4) @(posedge clk);
        #1;
        check("midrst bytes_taken", src_q.size(), 0);
        check("midrst write_count", wr_q.size(), 1);
        if (wr_q.size() > 0) check("midrst first_write", {wr_q[0].addr, wr_q[0].data}, {6'd0, 32'h20080005});
        check("midrst cpu_rst still", cpu_rst_o, 1);

        img.delete();
        src_q.delete();
        foreach (fixed_b[i]) if (i < 4) begin
            img.push_back(8'hAA + 8'(i * 8'h11));
            src_q.push_back(8'hAA + 8'(i * 8'h11));
        end
        run_session(1, 0, 0, dt);
        verify("after_midrst", 1, 6, dt);
        if (wr_q.size() > 0) check("after_midrst word", wr_q[0].data, 32'hAABBCCDD);

        for (int r = 0; r < 8; r++) begin
            int l;
            l = (r % 4 == 3) ? int'($urandom_range(60, 127)) : int'($urandom_range(0, 9));
            load_image(l, 1'b0);
            run_session(l, 2, int'($urandom_range(1, 30)), dt);
            verify($sformatf("rand%0d", r), l, -1, dt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
